winograd_tile_streamer: RTL and testbench

// - Sequential, parametrised tile extractor for Winograd F(4x4,3x3) convolution.
// - Latches a full IMG_ROWS x IMG_COLS image on a start pulse.
// - Emits one TILE x TILE overlapping tile per valid/ready handshake (stride STRIDE, zero padding past the edges).
// - Sits between the image buffer and the per-tile Winograd input transform.

---
 rtl/winograd_tile_streamer.sv | 177 +++++++++++++++++
 tb/tb_winograd_tile_streamer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/winograd_tile_streamer.sv
// winograd_tile_streamer
//   Latches a full image on a start pulse, then streams overlapping
//   TILE x TILE tiles (origin step STRIDE, zero padding past the edges)
//   toward the Winograd input transform, one tile per valid/ready handshake.
//   Optional macro WINO_TILE_COLMAJOR_EN selects column-major traversal;
//   when undefined the traversal is row-major.
//
// Handshake: tile_valid/tile_out/tile_r/tile_c/tile_last are registered.
//   Once tile_valid is high the payload is held bit-stable until the cycle
//   in which tile_valid & tile_ready are both high; that cycle is the
//   transfer, and the next tile (or the drop of tile_valid) appears on the
//   following cycle.
//
// The FSM state is kept in the 'state' signal so checkers can bind to it.

module winograd_tile_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_ROWS   = 10,
  parameter int IMG_COLS   = 12,
  parameter int TILE       = 6,
  parameter int STRIDE     = 4,
  localparam int TILES_R   = (IMG_ROWS + STRIDE - 1) / STRIDE,
  localparam int TILES_C   = (IMG_COLS + STRIDE - 1) / STRIDE,
  localparam int RW        = $clog2(TILES_R + 1),
  localparam int CW        = $clog2(TILES_C + 1),
  localparam int IW        = IMG_ROWS * IMG_COLS * DATA_WIDTH,
  localparam int TW        = TILE * TILE * DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] image_in,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] tile_out,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [RW-1:0] tile_r,
  output logic [CW-1:0] tile_c,
  output logic          tile_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] image_q;

  // Next tile position in traversal order and the tile it selects
  logic [RW-1:0] adv_r;
  logic [CW-1:0] adv_c;
  logic [RW-1:0] sel_r;
  logic [CW-1:0] sel_c;
  logic [IW-1:0] sel_img;
  logic [TW-1:0] tile_next;
  logic          last_next;
  logic          handshake;

  assign handshake = tile_valid & tile_ready;

  // Gather one tile from an image; coordinates past the edge read as zero.
  function automatic logic [TW-1:0] build_tile(input logic [IW-1:0] img,
                                               input logic [RW-1:0] r,
                                               input logic [CW-1:0] c);
    logic [TW-1:0] t;
    int            pr;
    int            pc;
    t = '0;
    for (int i = 0; i < TILE; i++) begin
      for (int j = 0; j < TILE; j++) begin
        pr = int'(r) * STRIDE + i;
        pc = int'(c) * STRIDE + j;
        if (pr < IMG_ROWS && pc < IMG_COLS) begin
          t[(i*TILE+j)*DATA_WIDTH +: DATA_WIDTH] =
            img[(pr*IMG_COLS+pc)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    return t;
  endfunction

  // Step the tile position one place along the selected traversal order
  always_comb begin
    adv_r = tile_r;
    adv_c = tile_c;
`ifdef WINO_TILE_COLMAJOR_EN
    if (tile_r == RW'(TILES_R - 1)) begin
      adv_r = '0;
      adv_c = tile_c + CW'(1);
    end else begin
      adv_r = tile_r + RW'(1);
    end
`else
    if (tile_c == CW'(TILES_C - 1)) begin
      adv_c = '0;
      adv_r = tile_r + RW'(1);
    end else begin
      adv_c = tile_c + CW'(1);
    end
`endif
  end

  // In IDLE the first tile comes straight from image_in (the register is
  // being loaded in the same cycle); afterwards from the latched image.
  always_comb begin
    sel_img   = image_q;
    sel_r     = adv_r;
    sel_c     = adv_c;
    if (state == IDLE) begin
      sel_img = image_in;
      sel_r   = '0;
      sel_c   = '0;
    end
    tile_next = build_tile(sel_img, sel_r, sel_c);
    last_next = (sel_r == RW'(TILES_R - 1)) && (sel_c == CW'(TILES_C - 1));
  end

  // Job FSM with registered outputs; reset aborts any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      image_q    <= '0;
      tile_out   <= '0;
      tile_valid <= 1'b0;
      tile_r     <= '0;
      tile_c     <= '0;
      tile_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            image_q    <= image_in;
            tile_out   <= tile_next;
            tile_r     <= '0;
            tile_c     <= '0;
            tile_last  <= last_next;
            tile_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (tile_last) begin
              tile_valid <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              tile_out  <= tile_next;
              tile_r    <= adv_r;
              tile_c    <= adv_c;
              tile_last <= last_next;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          tile_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_winograd_tile_streamer.sv
// tb_winograd_tile_streamer
//   Directed bench for winograd_tile_streamer: default 10x12 instance plus a
//   5x5 instance for the two-by-two tile grid. Honours WINO_TILE_COLMAJOR_EN
//   when choosing the expected traversal order.

module tb_winograd_tile_streamer;

  localparam int DW = 16;
  localparam int IR = 10;
  localparam int IC = 12;
  localparam int T  = 6;
  localparam int S  = 4;
  localparam int NR = 3;
  localparam int NC = 3;
  localparam int IW = IR * IC * DW;
  localparam int TW = T * T * DW;
  localparam int SW = 5 * 5 * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic          start;
  logic [IW-1:0] image_in;
  logic          busy;
  logic          done;
  logic [TW-1:0] tile_out;
  logic          tile_valid;
  logic          tile_ready;
  logic [1:0]    tile_r;
  logic [1:0]    tile_c;
  logic          tile_last;

  winograd_tile_streamer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .image_in   (image_in),
    .busy       (busy),
    .done       (done),
    .tile_out   (tile_out),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_r     (tile_r),
    .tile_c     (tile_c),
    .tile_last  (tile_last)
  );

  // ---------------- 5x5 instance ----------------
  logic          s_start;
  logic [SW-1:0] s_image;
  logic          s_busy;
  logic          s_done;
  logic [TW-1:0] s_tile;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    s_r;
  logic [1:0]    s_c;
  logic          s_last;

  winograd_tile_streamer #(.IMG_ROWS(5), .IMG_COLS(5)) dut_small (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .image_in   (s_image),
    .busy       (s_busy),
    .done       (s_done),
    .tile_out   (s_tile),
    .tile_valid (s_valid),
    .tile_ready (s_ready),
    .tile_r     (s_r),
    .tile_c     (s_c),
    .tile_last  (s_last)
  );

  // ---------------- scoreboard state ----------------
  int            errors = 0;
  int            checks = 0;
  logic [3:0]    exp_q[$];
  logic [IW-1:0] img_a;
  logic [IW-1:0] img_b;
  logic [TW-1:0] cap[NR][NC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tile(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [TW-1:0] t, input int i, input int j);
    return t[(i*T+j)*DW +: DW];
  endfunction

  // Reference tile: element (i,j) = image[tr*S+i][tc*S+j], zero outside the image
  function automatic logic [TW-1:0] exp_tile(input logic [IW-1:0] img, input int tr, input int tc);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < T; i++) begin
      for (int j = 0; j < T; j++) begin
        if (tr*S+i < IR && tc*S+j < IC)
          t[(i*T+j)*DW +: DW] = img[((tr*S+i)*IC + (tc*S+j))*DW +: DW];
      end
    end
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_order();
    exp_q.delete();
`ifdef WINO_TILE_COLMAJOR_EN
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) exp_q.push_back({2'(r), 2'(c)});
`else
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) exp_q.push_back({2'(r), 2'(c)});
`endif
  endtask

  task automatic pulse_start(input logic [IW-1:0] img);
    image_in = img;
    start    = 1'b1;
    step();
    start    = 1'b0;
    chk("valid_latency1", {63'd0, tile_valid}, 64'd1);
    chk("busy_in_emit", {63'd0, busy}, 64'd1);
  endtask

  // Drains up to max_hs tiles. mode 0: ready always high; mode 1: ready 1,0,0,...
  task automatic run_stream(input int mode, input logic [IW-1:0] img, input int max_hs);
    int            hs;
    int            cyc;
    bit            stalled;
    logic [TW-1:0] held_t;
    logic [1:0]    held_r;
    logic [1:0]    held_c;
    logic [3:0]    e;
    hs      = 0;
    cyc     = 0;
    stalled = 0;
    while (hs < max_hs && cyc < 200) begin
      tile_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      chk("valid_high", {63'd0, tile_valid}, 64'd1);
      if (stalled) begin
        chk_tile("stall_hold_tile", tile_out, held_t);
        chk("stall_hold_r", {62'd0, tile_r}, {62'd0, held_r});
        chk("stall_hold_c", {62'd0, tile_c}, {62'd0, held_c});
      end
      if (tile_valid && tile_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hf;
        chk("order_r", {62'd0, tile_r}, {62'd0, e[3:2]});
        chk("order_c", {62'd0, tile_c}, {62'd0, e[1:0]});
        chk_tile("tile_data", tile_out, exp_tile(img, int'(e[3:2]), int'(e[1:0])));
        chk("tile_last", {63'd0, tile_last}, {63'd0, (e == 4'b1010)});
        if (e != 4'hf) cap[e[3:2]][e[1:0]] = tile_out;
        hs++;
        stalled = 0;
      end else if (tile_valid) begin
        held_t  = tile_out;
        held_r  = tile_r;
        held_c  = tile_c;
        stalled = 1;
      end
      step();
      cyc++;
    end
    tile_ready = 1'b0;
    chk("stream_no_timeout", {63'd0, (cyc < 200)}, 64'd1);
  endtask

  task automatic check_done_tail();
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("valid_dropped", {63'd0, tile_valid}, 64'd0);
    chk("busy_in_done", {63'd0, busy}, 64'd1);
    step();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         n;
    int         cyc;
    logic [TW-1:0] s_cap;
    for (int r = 0; r < IR; r++) begin
      for (int c = 0; c < IC; c++) begin
        img_a[(r*IC+c)*DW +: DW] = 16'(r*16 + c);
        img_b[(r*IC+c)*DW +: DW] = 16'(16'h5000 + r*16 + c);
      end
    end
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) s_image[(r*5+c)*DW +: DW] = 16'(r*16 + c);

    rst        = 1'b1;
    start      = 1'b0;
    tile_ready = 1'b0;
    image_in   = '0;
    s_start    = 1'b0;
    s_ready    = 1'b0;
    step();
    step();
    chk("rst_valid", {63'd0, tile_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_last", {63'd0, tile_last}, 64'd0);
    chk("rst_rc", {60'd0, tile_r, tile_c}, 64'd0);
    chk_tile("rst_tile", tile_out, '0);
    rst = 1'b0;
    step();

    // 1: full stream, ready always high
    fill_order();
    pulse_start(img_a);
    run_stream(0, img_a, 9);
    chk("all_tiles_seen", 64'(exp_q.size()), 64'd0);
    check_done_tail();

    // hand-computed padding values
    chk("t02_e00", {48'd0, elem(cap[0][2], 0, 0)}, 64'h08);
    chk("t02_e03", {48'd0, elem(cap[0][2], 0, 3)}, 64'h0b);
    chk("t02_e04", {48'd0, elem(cap[0][2], 0, 4)}, 64'h00);
    chk("t02_e55", {48'd0, elem(cap[0][2], 5, 5)}, 64'h00);
    chk("t21_e10", {48'd0, elem(cap[2][1], 1, 0)}, 64'h94);
    chk("t21_e20", {48'd0, elem(cap[2][1], 2, 0)}, 64'h00);
    chk("t00_e11", {48'd0, elem(cap[0][0], 1, 1)}, 64'h11);

    // 2: backpressure 1,0,0,...
    fill_order();
    pulse_start(img_b);
    run_stream(1, img_b, 9);
    chk("bp_all_tiles_seen", 64'(exp_q.size()), 64'd0);
    check_done_tail();

    // 3: start and new image during EMIT are ignored
    fill_order();
    pulse_start(img_a);
    start      = 1'b1;
    image_in   = img_b;
    tile_ready = 1'b0;
    step();
    start      = 1'b0;
    chk("restart_ignored_rc", {60'd0, tile_r, tile_c}, 64'd0);
    chk_tile("restart_ignored_tile", tile_out, exp_tile(img_a, 0, 0));
    run_stream(0, img_a, 9);
    check_done_tail();

    // 4: reset after the 4th handshake aborts the job
    fill_order();
    pulse_start(img_b);
    run_stream(0, img_b, 4);
    rst = 1'b1;
    step();
    chk("abort_valid", {63'd0, tile_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_last", {63'd0, tile_last}, 64'd0);
    chk("abort_rc", {60'd0, tile_r, tile_c}, 64'd0);
    chk_tile("abort_tile", tile_out, '0);
    rst = 1'b0;
    step();
    chk("abort_no_done", {63'd0, done}, 64'd0);
    fill_order();
    pulse_start(img_b);
    run_stream(0, img_b, 9);
    check_done_tail();

    // 5: 5x5 image -> 2x2 tiles
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_ready = 1'b1;
    n       = 0;
    cyc     = 0;
    s_cap   = '0;
    while (n < 4 && cyc < 50) begin
      if (s_valid) begin
        if (s_r == 2'd1 && s_c == 2'd1) s_cap = s_tile;
        chk("small_last", {63'd0, s_last}, {63'd0, (n == 3)});
        n++;
      end
      step();
      cyc++;
    end
    s_ready = 1'b0;
    chk("small_count", 64'(n), 64'd4);
    chk("small_done", {63'd0, s_done}, 64'd1);
    chk("small_t11_e00", {48'd0, elem(s_cap, 0, 0)}, 64'h44);
    chk("small_t11_e10", {48'd0, elem(s_cap, 1, 0)}, 64'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
